// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults, state encoding and helpers for the FIFO write arbiter.
// Imported by the interface, the round-robin selector and the top level.
package fifo_ctrl_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 16;
  localparam int MAX_BURST_DEF = 4;
  localparam int WR_COUNT_W    = 16;
  // Wide enough to count up to MAX_BURST-1 for MAX_BURST in 1..16.
  localparam int BURST_CNT_W   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bundle plus FIFO write port of the write arbiter.
// The slave modport is the arbiter; the master modport is whoever drives requests.
interface fifo_wr_arbiter_if
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) ();

  // Handshake: requester i transfers one word on a rising edge where
  // req_valid[i] and req_ready[i] are both high; ready never depends on valid,
  // and a word presented with req_valid must stay stable until accepted.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_data;

  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic [WR_COUNT_W-1:0]     wr_count;
  state_t                    state_dbg;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data, grant_id, busy, wr_count, state_dbg
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_data, grant_id, busy, wr_count, state_dbg
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts at rr_ptr+1 and wraps,
// so the previously granted requester has the lowest priority.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [ID_W-1:0] cand;

  // Scan from the lowest priority down so the highest-priority hit is written last.
  always_comb begin
    winner  = rr_ptr;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NUM_REQ word streams into one FIFO write port.
// The write path is combinational so fifo_full blocks a transfer in the same cycle.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             wr_clk,
  input  logic             reset_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(MAX_BURST - 1);

  state_t                 state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        grant_id_q;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [WR_COUNT_W-1:0]  wr_count_q;
  logic                   busy_q;

  logic [ID_W-1:0]        winner;
  logic                   any_req;
  logic                   in_burst;
  logic                   gnt_valid;
  logic                   gnt_last;
  logic [DATA_W-1:0]      gnt_data;
  logic                   xfer;
  logic                   burst_end;
  logic [NUM_REQ-1:0]     ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Pick out the granted requester's lane.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id_q) begin
        gnt_valid = bus.req_valid[i];
        gnt_last  = bus.req_last[i];
        gnt_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Inputs are ignored while reset is asserted, so no write escapes in that cycle.
  assign in_burst  = (state == ST_BURST) && reset_n;
  assign xfer      = in_burst && gnt_valid && !bus.fifo_full;
  assign burst_end = gnt_last || (burst_cnt == LAST_BEAT);

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_burst && (ID_W'(i) == grant_id_q)) begin
        ready[i] = !bus.fifo_full;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_data  = xfer ? gnt_data : '0;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.state_dbg  = state;

  always_ff @(posedge wr_clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      burst_cnt  <= '0;
      wr_count_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state      <= ST_BURST;
            busy_q     <= 1'b1;
            grant_id_q <= winner;
            rr_ptr     <= winner;
            burst_cnt  <= '0;
          end
        end
        ST_BURST: begin
          // A dropped valid abandons the burst; full with valid simply stalls.
          if (!gnt_valid) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (xfer) begin
            burst_cnt  <= burst_cnt + 1'b1;
            wr_count_q <= wr_count_q + 1'b1;
            if (burst_end) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters.
REQ-002 Parameter DATA_W, default 16, FIFO word width.
REQ-003 Parameter MAX_BURST, default 4, maximum words per grant (range 1..16).
REQ-004 wr_clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester word valid.
REQ-007 req_data  in  NUM_REQ*DATA_W  per-requester word; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_last  in  NUM_REQ  marks the final word of a requester's burst.
REQ-009 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-010 fifo_full  in  1  FIFO write-side full flag.
REQ-011 fifo_wr_en  out  1  FIFO write enable.
REQ-012 fifo_data  out  DATA_W  FIFO write data.
REQ-013 grant_id  out  log2(NUM_REQ)  index of the granted requester.
REQ-014 busy  out  1  high while in BURST.
REQ-015 wr_count  out  16  total words written since reset; wraps at 16'hFFFF -> 0.

Function
REQ-016 States: IDLE and BURST only.
REQ-017 IDLE: req_ready = 0, fifo_wr_en = 0, busy = 0; if any req_valid is set, select the winner round-robin starting at (rr_ptr+1) mod NUM_REQ, register grant_id = winner and rr_ptr = winner, clear burst_cnt, and go to BURST.
REQ-018 BURST: req_ready[grant_id] = !fifo_full; all other ready bits are 0.
REQ-019 Write path is combinational:
  - fifo_wr_en = req_valid[grant_id] & req_ready[grant_id] while in BURST.
  - fifo_data = req_data slice of grant_id.
  - zero latency, so fifo_full blocks the same cycle.
REQ-020 fifo_data is 0 whenever fifo_wr_en is 0.
REQ-021 Each transfer increments burst_cnt and wr_count.
REQ-022 BURST -> IDLE on the edge following:
  - a transfer with req_last = 1, or
  - a transfer with burst_cnt == MAX_BURST-1, or
  - a cycle with req_valid[grant_id] = 0 (abandon).
REQ-023 BURST with fifo_full = 1 and req_valid = 1: stall, with no state, count or grant change.
REQ-024 Latency: request valid in IDLE at cycle t gives first write at cycle t+1 if not full; exactly one IDLE cycle separates consecutive bursts.
REQ-025 grant_id holds its last value in IDLE.
REQ-026 req_valid and req_last of non-granted requesters are ignored.

Reset
REQ-027 On any rising edge with reset_n = 0:
  - state = IDLE, rr_ptr = NUM_REQ-1 (requester 0 first), grant_id = 0, burst_cnt = 0, wr_count = 0.
  - hence req_ready = 0, fifo_wr_en = 0, fifo_data = 0, busy = 0.
REQ-028 Reset asserted mid-burst aborts the burst with no further writes from the next cycle; inputs are ignored while reset_n = 0.

Structure
REQ-029 Shared package fifo_ctrl_pkg holds NUM_REQ, DATA_W and MAX_BURST defaults plus the IDLE/BURST state encoding.
REQ-030 Round-robin selection is a combinational sub-module rr_arbiter:
  - inputs: request vector and rr_ptr.
  - outputs: winner index and any-request flag.
REQ-031 The top level contains the FSM, burst_cnt, wr_count and the data mux.

Verification
REQ-032 Reset: reset_n = 0 for 2 cycles, req_valid = 4'b1111 -> req_ready = 0, fifo_wr_en = 0, grant_id = 0, busy = 0, wr_count = 0.
REQ-033 Single burst: req_valid[2] = 1 with data 16'hA000..16'hA003, req_last on the 4th word -> grant_id = 2 one cycle later, then 4 consecutive writes A000..A003, then IDLE, wr_count = 4.
REQ-034 Round-robin: all 4 valid continuously, req_last = 0 -> bursts of 4 words granted to 0,1,2,3,0, with one idle cycle between bursts.
REQ-035 Backpressure: requester 1 granted, fifo_full = 1 for 3 cycles after word 2 -> ready = 0 and wr_en = 0 for those 3 cycles, word 3 written on the first non-full cycle, burst ends after word 4.
REQ-036 Abandon: requester 3 drops valid after 1 word -> IDLE next cycle; with req 0 valid, next grant_id = 0.
REQ-037 Reset mid-burst: reset_n = 0 during word 3 of a req-2 burst -> no write on the next cycle, wr_count = 0; after release, req_valid = 4'b0110 grants requester 1 first.
